// File: rtl/mac_operand_loader.sv
// mac_operand_loader: packs a header/A/B byte stream into lane-ordered
// operand vectors for the SIMD MAC array, presents them with a one-cycle
// issue pulse and holds them stable while the chained result drains.
module mac_operand_loader #(
  parameter int bw       = 8,
  parameter int num_MAC  = 32,
  parameter int HOLD_CYC = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [bw-1:0]           in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    abort,
  output logic [1:0]              mode,
  output logic [bw*num_MAC-1:0]   din_a,
  output logic [bw*num_MAC-1:0]   din_b,
  output logic                    issue,
  output logic                    busy
);

  // Lane counter never exceeds num_MAC-1; keep at least one bit for num_MAC=1.
  localparam int CW = (num_MAC > 1) ? $clog2(num_MAC) : 1;
  // Hold counter only ever holds HOLD_CYC-1 down to 0.
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int VW = bw * num_MAC;

  localparam logic [CW-1:0] CNT_LAST  = CW'(num_MAC - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ISSUE  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [HW-1:0]   hold_r;
  logic [1:0]      mode_hdr_r;
  logic [VW-1:0]   shadow_a_r;
  logic [VW-1:0]   shadow_b_r;
  logic [VW-1:0]   shadow_b_next_s;
  logic            accepting_s;
  logic            xfer_s;
  logic            last_s;
  int              lane_base_s;

  // Ready is a pure state decode, forced low while reset is asserted.
  assign accepting_s = (state_r == S_IDLE) || (state_r == S_LOAD_A) || (state_r == S_LOAD_B);
  assign in_ready    = accepting_s && !rst;
  assign xfer_s      = in_valid && in_ready;
  assign last_s      = (cnt_r == CNT_LAST);
  assign lane_base_s = int'(cnt_r) * bw;
  assign issue       = (state_r == S_ISSUE);
  assign busy        = (state_r != S_IDLE);

  // B vector including the byte being written this cycle, so the final lane
  // lands in din_b on the same edge that enters ISSUE.
  always_comb begin
    shadow_b_next_s = shadow_b_r;
    shadow_b_next_s[lane_base_s +: bw] = in_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: abort only matters while frame bytes are being taken.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (abort) begin
          state_next_s = S_IDLE;
        end else if (xfer_s) begin
          state_next_s = S_LOAD_A;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD_A: begin
        if (abort) begin
          state_next_s = S_IDLE;
        end else if (xfer_s && last_s) begin
          state_next_s = S_LOAD_B;
        end else begin
          state_next_s = S_LOAD_A;
        end
      end
      S_LOAD_B: begin
        if (abort) begin
          state_next_s = S_IDLE;
        end else if (xfer_s && last_s) begin
          state_next_s = S_ISSUE;
        end else begin
          state_next_s = S_LOAD_B;
        end
      end
      S_ISSUE: begin
        state_next_s = S_HOLD;
      end
      S_HOLD: begin
        if (hold_r == HOLD_ZERO) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_HOLD;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Datapath: lane counter, shadow fill, output capture and hold countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= CNT_ZERO;
      hold_r     <= HOLD_ZERO;
      mode_hdr_r <= 2'b00;
      shadow_a_r <= {VW{1'b0}};
      shadow_b_r <= {VW{1'b0}};
      mode       <= 2'b00;
      din_a      <= {VW{1'b0}};
      din_b      <= {VW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (abort) begin
            cnt_r <= CNT_ZERO;
          end else if (xfer_s) begin
            mode_hdr_r <= in_data[1:0];
            cnt_r      <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_LOAD_A: begin
          if (abort) begin
            cnt_r <= CNT_ZERO;
          end else if (xfer_s) begin
            shadow_a_r[lane_base_s +: bw] <= in_data;
            cnt_r <= last_s ? CNT_ZERO : (cnt_r + CNT_ONE);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_LOAD_B: begin
          if (abort) begin
            cnt_r <= CNT_ZERO;
          end else if (xfer_s) begin
            shadow_b_r <= shadow_b_next_s;
            if (last_s) begin
              cnt_r <= CNT_ZERO;
              din_a <= shadow_a_r;
              din_b <= shadow_b_next_s;
              mode  <= mode_hdr_r;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_ISSUE: begin
          hold_r <= HOLD_LOAD;
        end
        S_HOLD: begin
          if (hold_r != HOLD_ZERO) begin
            hold_r <= hold_r - HOLD_ONE;
          end else begin
            hold_r <= HOLD_ZERO;
          end
        end
        default: begin
          cnt_r  <= CNT_ZERO;
          hold_r <= HOLD_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Bench for mac_operand_loader: frame-level reference model with a per-cycle
// compare process, plus literal checks on the default and num_MAC=1 builds.
module tb_mac_operand_loader;

  localparam int L = 32;
  localparam int H = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         abort = 1'b0;
  logic         in_ready;
  logic [1:0]   mode;
  logic [255:0] din_a;
  logic [255:0] din_b;
  logic         issue;
  logic         busy;

  logic         rst2 = 1'b1;
  logic [7:0]   in_data2 = 8'h00;
  logic         in_valid2 = 1'b0;
  logic         abort2 = 1'b0;
  logic         in_ready2;
  logic [1:0]   mode2;
  logic [7:0]   din_a2;
  logic [7:0]   din_b2;
  logic         issue2;
  logic         busy2;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mac_operand_loader #(.bw(8), .num_MAC(L), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .mode(mode), .din_a(din_a),
    .din_b(din_b), .issue(issue), .busy(busy)
  );

  mac_operand_loader #(.bw(8), .num_MAC(1), .HOLD_CYC(1)) dut1 (
    .clk(clk), .rst(rst2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .abort(abort2), .mode(mode2), .din_a(din_a2),
    .din_b(din_b2), .issue(issue2), .busy(busy2)
  );

  // Reference model: bytes of the frame in progress, cycles left blocked.
  logic [7:0]   mq[$];
  int           m_block = 0;
  logic         m_issue = 1'b0;
  logic [1:0]   m_mode = 2'b00;
  logic [255:0] m_a = '0;
  logic [255:0] m_b = '0;

  logic [7:0]   fa[L];
  logic [7:0]   fb[L];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model across one clock edge with the inputs seen at that edge.
  task automatic model_step(input logic v, input logic [7:0] d, input logic ab, input logic r);
    if (r) begin
      mq.delete();
      m_block = 0;
      m_issue = 1'b0;
      m_mode  = 2'b00;
      m_a     = '0;
      m_b     = '0;
    end else begin
      m_issue = 1'b0;
      if (m_block > 0) begin
        m_block--;
      end else if (ab) begin
        mq.delete();
      end else if (v) begin
        mq.push_back(d);
        if (mq.size() == 2*L + 1) begin
          m_mode = mq[0][1:0];
          for (int i = 0; i < L; i++) begin
            m_a[i*8 +: 8] = mq[1+i];
            m_b[i*8 +: 8] = mq[1+L+i];
          end
          mq.delete();
          m_block = H + 1;
          m_issue = 1'b1;
        end
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", {255'd0, in_ready}, {255'd0, (!rst && m_block == 0)});
      chk("issue", {255'd0, issue}, {255'd0, m_issue});
      chk("busy",  {255'd0, busy},  {255'd0, (m_block > 0 || mq.size() > 0)});
      chk("mode",  {254'd0, mode},  {254'd0, m_mode});
      chk("din_a", din_a, m_a);
      chk("din_b", din_b, m_b);
    end
  end

  task automatic tick(input logic v, input logic [7:0] d, input logic ab, input logic r);
    in_valid = v;
    in_data  = d;
    abort    = ab;
    rst      = r;
    @(posedge clk);
    model_step(v, d, ab, r);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    for (int g = 0; g < gap; g++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 100 && !acc; k++) begin
      acc = (m_block == 0);
      tick(1'b1, b, 1'b0, 1'b0);
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %0h not accepted within 100 cycles", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int gap);
    send(hdr, gap);
    for (int i = 0; i < L; i++) send(fa[i], gap);
    for (int i = 0; i < L; i++) send(fb[i], gap);
  endtask

  task automatic tick2(input logic v, input logic [7:0] d, input logic r);
    in_valid2 = v;
    in_data2  = d;
    rst2      = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_frame1(input string tag);
    chk({tag, "_issue"}, {255'd0, issue}, 256'd1);
    chk({tag, "_mode"}, {254'd0, mode}, 256'd2);
    chk({tag, "_a0"}, {248'd0, din_a[7:0]}, 256'h01);
    chk({tag, "_a31"}, {248'd0, din_a[255:248]}, 256'h20);
    chk({tag, "_b"}, din_b, {32{8'h03}});
  endtask

  initial begin
    int n;
    // Reset and verify reset state.
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    cmp_en = 1'b1;
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_ready", {255'd0, in_ready}, 256'd1);
    chk("rst_dina", din_a, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);

    // Frame 1, back-to-back.
    for (int i = 0; i < L; i++) begin fa[i] = 8'(i + 1); fb[i] = 8'h03; end
    send_frame(8'h02, 0);
    check_frame1("t1");
    n = 0;
    while (!in_ready && n < 100) begin n++; tick(1'b0, 8'h00, 1'b0, 1'b0); end
    chk("t1_ready_low_cycles", n, H + 1);

    // Same frame with a bubble before every byte.
    send_frame(8'h02, 1);
    check_frame1("t2");
    for (int k = 0; k < H + 2; k++) tick(1'b0, 8'h00, 1'b0, 1'b0);

    // Abort after 10 A bytes (a concurrent byte is discarded), then a full frame.
    send(8'hFE, 0);
    for (int i = 0; i < 10; i++) send(8'hC0, 0);
    tick(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t3_busy_after_abort", {255'd0, busy}, 256'd0);
    chk("t3_a31_kept", {248'd0, din_a[255:248]}, 256'h20);
    for (int i = 0; i < L; i++) begin fa[i] = 8'hFF; fb[i] = 8'h00; end
    send_frame(8'h01, 0);
    chk("t3_issue", {255'd0, issue}, 256'd1);
    chk("t3_mode", {254'd0, mode}, 256'd1);
    chk("t3_a", din_a, {32{8'hFF}});
    chk("t3_b", din_b, 256'd0);
    for (int k = 0; k < H + 2; k++) tick(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset during LOAD_B, then a fresh frame.
    send(8'h02, 0);
    for (int i = 0; i < L; i++) send(8'h11, 0);
    for (int i = 0; i < 5; i++) send(8'h22, 0);
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("t4_ready_in_rst", {255'd0, in_ready}, 256'd0);
    tick(1'b1, 8'h22, 1'b0, 1'b1);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t4_dina_zero", din_a, 256'd0);
    chk("t4_mode_zero", {254'd0, mode}, 256'd0);
    chk("t4_busy_zero", {255'd0, busy}, 256'd0);
    for (int i = 0; i < L; i++) begin fa[i] = 8'(8'h80 + i); fb[i] = 8'(8'h10 + i); end
    send_frame(8'h02, 0);
    chk("t4_a5", {248'd0, din_a[47:40]}, 256'h85);
    chk("t4_b31", {248'd0, din_b[255:248]}, 256'h2F);
    for (int k = 0; k < H + 2; k++) tick(1'b0, 8'h00, 1'b0, 1'b0);

    // Two frames with no gap; the second header waits out ISSUE/HOLD.
    for (int i = 0; i < L; i++) begin fa[i] = 8'(8'h40 + i); fb[i] = ~8'(i); end
    send_frame(8'h00, 0);
    for (int i = 0; i < L; i++) begin fa[i] = 8'hA5; fb[i] = 8'h5A; end
    send(8'h03, 0);
    chk("t5_a0_held", {248'd0, din_a[7:0]}, 256'h40);
    for (int i = 0; i < L; i++) send(fa[i], 0);
    for (int i = 0; i < L; i++) send(fb[i], 0);
    chk("t5_mode", {254'd0, mode}, 256'd3);
    chk("t5_a", din_a, {32{8'hA5}});
    chk("t5_b", din_b, {32{8'h5A}});
    for (int k = 0; k < H + 2; k++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    cmp_en = 1'b0;

    // num_MAC=1, HOLD_CYC=1 build.
    tick2(1'b0, 8'h00, 1'b1);
    chk("m1_ready_in_rst", {255'd0, in_ready2}, 256'd0);
    tick2(1'b1, 8'h03, 1'b0);
    chk("m1_busy", {255'd0, busy2}, 256'd1);
    tick2(1'b1, 8'h7F, 1'b0);
    tick2(1'b1, 8'h80, 1'b0);
    chk("m1_issue", {255'd0, issue2}, 256'd1);
    chk("m1_a", {248'd0, din_a2}, 256'h7F);
    chk("m1_b", {248'd0, din_b2}, 256'h80);
    chk("m1_mode", {254'd0, mode2}, 256'd3);
    chk("m1_ready_issue", {255'd0, in_ready2}, 256'd0);
    tick2(1'b0, 8'h00, 1'b0);
    chk("m1_ready_hold", {255'd0, in_ready2}, 256'd0);
    chk("m1_issue_off", {255'd0, issue2}, 256'd0);
    tick2(1'b0, 8'h00, 1'b0);
    chk("m1_ready_back", {255'd0, in_ready2}, 256'd1);
    chk("m1_busy_off", {255'd0, busy2}, 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
